// File: rtl/bcd_stopwatch.sv
// MM:SS BCD stopwatch advanced by rising edges of a slow clock synchronous to cin.
// Optional lap-freeze display is enabled with `define STOPWATCH_LAP_EN.
module bcd_stopwatch #(
   parameter int TICKS_PER_STEP = 1,
   parameter int MAX_MINUTES    = 59
) (
   input  logic       cin,
   input  logic       rst_n,
   input  logic       slow_clk,
   input  logic       start_btn,
   input  logic       clear_btn,
`ifdef STOPWATCH_LAP_EN
   input  logic       lap_btn,
   output logic       lap_active,
`endif
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       running,
   output logic       wrap
);

   localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_STEP - 1);
   localparam logic [3:0] MAX_MT     = 4'(MAX_MINUTES / 10);
   localparam logic [3:0] MAX_MO     = 4'(MAX_MINUTES % 10);

`ifdef STOPWATCH_LAP_EN
   localparam int NIN = 4;
   logic [NIN-1:0] in_raw;
   assign in_raw = {lap_btn, clear_btn, start_btn, slow_clk};
`else
   localparam int NIN = 3;
   logic [NIN-1:0] in_raw;
   assign in_raw = {clear_btn, start_btn, slow_clk};
`endif

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t         state;
   logic [NIN-1:0] in_s, in_s_d, rise;
   logic [7:0]     presc;
   logic [3:0]     cnt_so, cnt_st, cnt_mo, cnt_mt;
   logic [3:0]     nxt_so, nxt_st, nxt_mo, nxt_mt;
   logic           nxt_wrap;
   logic           slow_rise, start_rise, clear_rise;
   logic           count_en, step, do_clear;

   // History resets high so an input already high at reset release is not an edge.
   always_ff @(posedge cin or negedge rst_n) begin
      if (!rst_n) begin
         in_s   <= '1;
         in_s_d <= '1;
      end else begin
         in_s   <= in_raw;
         in_s_d <= in_s;
      end
   end

   assign rise       = in_s & ~in_s_d;
   assign slow_rise  = rise[0];
   assign start_rise = rise[1];
   assign clear_rise = rise[2];

   // Counting and clearing are decided from the pre-transition state.
   assign count_en = (state == RUN) && slow_rise;
   assign step     = count_en && (presc == PRESC_LAST);
   assign do_clear = clear_rise && (state != RUN);

   always_comb begin
      nxt_so   = cnt_so;
      nxt_st   = cnt_st;
      nxt_mo   = cnt_mo;
      nxt_mt   = cnt_mt;
      nxt_wrap = 1'b0;
      if (step) begin
         if (cnt_so != 4'd9) begin
            nxt_so = cnt_so + 4'd1;
         end else begin
            nxt_so = 4'd0;
            if (cnt_st != 4'd5) begin
               nxt_st = cnt_st + 4'd1;
            end else begin
               nxt_st = 4'd0;
               if (cnt_mt == MAX_MT && cnt_mo == MAX_MO) begin
                  nxt_mo   = 4'd0;
                  nxt_mt   = 4'd0;
                  nxt_wrap = 1'b1;
               end else if (cnt_mo != 4'd9) begin
                  nxt_mo = cnt_mo + 4'd1;
               end else begin
                  nxt_mo = 4'd0;
                  nxt_mt = cnt_mt + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge cin or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         running <= 1'b0;
         wrap    <= 1'b0;
         presc   <= 8'd0;
         cnt_so  <= 4'd0;
         cnt_st  <= 4'd0;
         cnt_mo  <= 4'd0;
         cnt_mt  <= 4'd0;
      end else begin
         wrap <= nxt_wrap;
         unique case (state)
            IDLE: begin
               if (!clear_rise && start_rise) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (start_rise) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end
            end
            PAUSE: begin
               if (clear_rise) begin
                  state <= IDLE;
               end else if (start_rise) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase
         if (do_clear) begin
            presc  <= 8'd0;
            cnt_so <= 4'd0;
            cnt_st <= 4'd0;
            cnt_mo <= 4'd0;
            cnt_mt <= 4'd0;
         end else if (count_en) begin
            presc  <= step ? 8'd0 : presc + 8'd1;
            cnt_so <= nxt_so;
            cnt_st <= nxt_st;
            cnt_mo <= nxt_mo;
            cnt_mt <= nxt_mt;
         end
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic [3:0] lap_so, lap_st, lap_mo, lap_mt;

   // Freeze snapshot; the live count keeps running underneath.
   always_ff @(posedge cin or negedge rst_n) begin
      if (!rst_n) begin
         lap_active <= 1'b0;
         lap_so     <= 4'd0;
         lap_st     <= 4'd0;
         lap_mo     <= 4'd0;
         lap_mt     <= 4'd0;
      end else if (clear_rise && state == PAUSE) begin
         lap_active <= 1'b0;
      end else if (rise[3]) begin
         if (lap_active) begin
            lap_active <= 1'b0;
         end else if (state == RUN) begin
            lap_active <= 1'b1;
            lap_so     <= cnt_so;
            lap_st     <= cnt_st;
            lap_mo     <= cnt_mo;
            lap_mt     <= cnt_mt;
         end
      end
   end

   assign sec_ones = lap_active ? lap_so : cnt_so;
   assign sec_tens = lap_active ? lap_st : cnt_st;
   assign min_ones = lap_active ? lap_mo : cnt_mo;
   assign min_tens = lap_active ? lap_mt : cnt_mt;
`else
   assign sec_ones = cnt_so;
   assign sec_tens = cnt_st;
   assign min_ones = cnt_mo;
   assign min_tens = cnt_mt;
`endif

endmodule
